// File: rtl/rtc_lector.sv
// rtc_lector: periodic read sweep of the nine RTC time/date/timer registers.
// The bus is multiplexed: an address phase latched with wr_n is followed by a
// data phase read with rd_n. Captured bytes go into a shadow set, and all nine
// values are committed to the outputs together once the whole sweep succeeds.
module rtc_lector #(
  parameter int T_PULSE      = 10,
  parameter int T_GAP        = 10,
  parameter int SWEEP_PERIOD = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rd_req,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       busy,
  output logic       sweep_done,
  output logic       bcd_err,
  output logic [7:0] rsegr,
  output logic [7:0] rminr,
  output logic [7:0] rhorar,
  output logic [7:0] diar,
  output logic [7:0] mesr,
  output logic [7:0] annor,
  output logic [7:0] tsegr,
  output logic [7:0] tminr,
  output logic [7:0] thorar
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam int PW    = $clog2(SWEEP_PERIOD);

  localparam logic [TW-1:0] PULSE_LD = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(T_GAP - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(SWEEP_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_COMMIT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_idx;
  logic          r_err;
  logic          r_pend;
  logic [PW-1:0] r_period;
  logic [7:0]    r_shadow [9];
  logic [7:0]    r_val    [9];

  logic w_wrap;
  logic w_start;
  logic w_gap2_end;
  logic w_abort;

  // RTC register address for each sweep slot
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  // A byte is usable only if both nibbles are decimal digits
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign w_wrap     = (r_period == P_LAST);
  assign w_start    = (r_state == S_IDLE) && r_pend && enable;
  assign w_gap2_end = (r_state == S_GAP2) && (r_timer == '0);
  assign w_abort    = w_gap2_end && !enable;

  // Free-running sweep period counter and the single-entry request latch.
  // A new request in the same cycle a sweep starts is kept, so it is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_period <= w_wrap ? '0 : r_period + 1'b1;
      if (w_wrap || rd_req || w_abort)
        r_pend <= 1'b1;
      else if (w_start)
        r_pend <= 1'b0;
    end
  end

  // Bus sequencer: phase timing, registered strobes, shadow capture, commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_idx      <= 4'd0;
      r_err      <= 1'b0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      a_d        <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= 8'h00;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      bcd_err    <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_shadow[i] <= 8'h00;
        r_val[i]    <= (i == 3 || i == 4) ? 8'h01 : 8'h00;
      end
    end else begin
      sweep_done <= 1'b0;
      if (r_timer != '0)
        r_timer <= r_timer - 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_ADDR;
            r_timer <= PULSE_LD;
            r_idx   <= 4'd0;
            r_err   <= 1'b0;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            wr_n    <= 1'b0;
            a_d     <= 1'b0;
            ad_oe   <= 1'b1;
            ad_out  <= reg_addr(4'd0);
          end
        end
        S_ADDR: begin
          if (r_timer == '0) begin
            r_state <= S_GAP1;
            r_timer <= GAP_LD;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_oe   <= 1'b0;
          end
        end
        S_GAP1: begin
          if (r_timer == '0) begin
            r_state <= S_DATA;
            r_timer <= PULSE_LD;
            cs_n    <= 1'b0;
            rd_n    <= 1'b0;
            a_d     <= 1'b1;
          end
        end
        S_DATA: begin
          if (r_timer == '0) begin
            // An invalid byte falls back to the committed value of that field
            if (bcd_ok(ad_in)) begin
              r_shadow[r_idx] <= ad_in;
            end else begin
              r_shadow[r_idx] <= r_val[r_idx];
              r_err           <= 1'b1;
            end
            r_state <= S_GAP2;
            r_timer <= GAP_LD;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
          end
        end
        S_GAP2: begin
          if (w_gap2_end) begin
            if (!enable) begin
              // Yield to the write path; the request latch restarts the sweep
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else if (r_idx == 4'd8) begin
              r_state    <= S_COMMIT;
              sweep_done <= 1'b1;
              bcd_err    <= r_err;
              for (int i = 0; i < 9; i++)
                r_val[i] <= r_shadow[i];
            end else begin
              r_state <= S_ADDR;
              r_timer <= PULSE_LD;
              r_idx   <= r_idx + 4'd1;
              cs_n    <= 1'b0;
              wr_n    <= 1'b0;
              a_d     <= 1'b0;
              ad_oe   <= 1'b1;
              ad_out  <= reg_addr(r_idx + 4'd1);
            end
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsegr  = r_val[0];
  assign rminr  = r_val[1];
  assign rhorar = r_val[2];
  assign diar   = r_val[3];
  assign mesr   = r_val[4];
  assign annor  = r_val[5];
  assign tsegr  = r_val[6];
  assign tminr  = r_val[7];
  assign thorar = r_val[8];

endmodule
